// File: rtl/compare_pulse_gen.sv
// compare_pulse_gen: output-compare timer. Counts N cycles (counter starts
// at 1), then drives compare_out high for max(L,1) cycles, once or as a
// repeating low-N/high-L train. Shadow registers take software loads at any
// time; active registers are refreshed from them on every entry to COUNT.
//
// Load interface: cmp_load is a single-cycle strobe with no back-pressure.
// The block always accepts it; the values land in the shadow registers, and
// if the same edge enters COUNT they bypass straight into the active set.
module compare_pulse_gen #(
  parameter int WIDTH = 32,
  parameter int PW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_enable,
  input  logic             cmp_load,
  input  logic [WIDTH-1:0] cmp_value,
  input  logic [PW-1:0]    pulse_len,
  input  logic             periodic,
  output logic [WIDTH-1:0] counter,
  output logic [2:0]       state,
  output logic             compare_out,
  output logic             compare_match,
  output logic             done
);

  localparam logic [2:0] S_IDLE  = 3'b000;
  localparam logic [2:0] S_COUNT = 3'b010;
  localparam logic [2:0] S_PULSE = 3'b011;
  localparam logic [2:0] S_DONE  = 3'b100;

  logic [2:0]       next_state;
  logic [WIDTH-1:0] shadow_n, active_n, eff_n;
  logic [PW-1:0]    shadow_l, active_l, eff_l;
  logic             shadow_p, active_p, eff_p;
  logic [PW-1:0]    pulse_cnt, next_pulse_cnt;
  logic [WIDTH-1:0] next_counter;
  logic             next_compare_out, next_compare_match, next_done;
  logic             load_active;

  // Effective shadow view: a load on this edge is visible immediately.
  always_comb begin
    eff_n = cmp_load ? cmp_value : shadow_n;
    eff_l = cmp_load ? pulse_len : shadow_l;
    eff_p = cmp_load ? periodic  : shadow_p;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; unknown encodings fall back to IDLE.
  always_comb begin
    next_state = S_IDLE;
    case (state)
      S_IDLE:  next_state = (timer_enable && eff_n != '0) ? S_COUNT : S_IDLE;
      S_COUNT: begin
        if (!timer_enable)            next_state = S_IDLE;
        else if (counter == active_n) next_state = S_PULSE;
        else                          next_state = S_COUNT;
      end
      S_PULSE: begin
        if (pulse_cnt == PW'(1))
          next_state = (active_p && timer_enable && eff_n != '0) ? S_COUNT : S_DONE;
        else
          next_state = S_PULSE;
      end
      S_DONE:  next_state = timer_enable ? S_DONE : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output/datapath next values, registered below.
  always_comb begin
    next_counter       = counter;
    next_compare_out   = compare_out;
    next_compare_match = 1'b0;
    next_pulse_cnt     = pulse_cnt;
    load_active        = 1'b0;
    case (state)
      S_IDLE: begin
        if (next_state == S_COUNT) begin
          next_counter = WIDTH'(1);
          load_active  = 1'b1;
        end
      end
      S_COUNT: begin
        if (next_state == S_PULSE) begin
          next_compare_out   = 1'b1;
          next_compare_match = 1'b1;
          next_pulse_cnt     = (active_l == '0) ? PW'(1) : active_l;
        end else if (next_state == S_COUNT) begin
          next_counter = counter + WIDTH'(1);
        end
      end
      S_PULSE: begin
        next_pulse_cnt = pulse_cnt - PW'(1);
        if (pulse_cnt == PW'(1)) next_compare_out = 1'b0;
        if (next_state == S_COUNT) begin
          next_counter = WIDTH'(1);
          load_active  = 1'b1;
        end
      end
      S_DONE: ;
      default: next_compare_out = 1'b0;
    endcase
    next_done = (next_state == S_DONE) && timer_enable;
  end

  // Registered outputs and pulse-length counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter       <= '0;
      compare_out   <= 1'b0;
      compare_match <= 1'b0;
      done          <= 1'b0;
      pulse_cnt     <= '0;
    end else begin
      counter       <= next_counter;
      compare_out   <= next_compare_out;
      compare_match <= next_compare_match;
      done          <= next_done;
      pulse_cnt     <= next_pulse_cnt;
    end
  end

  // Shadow registers capture every load strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_n <= '0;
      shadow_l <= '0;
      shadow_p <= 1'b0;
    end else if (cmp_load) begin
      shadow_n <= cmp_value;
      shadow_l <= pulse_len;
      shadow_p <= periodic;
    end
  end

  // Active registers refresh only on entry to COUNT, so a running period is never altered.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_n <= '0;
      active_l <= '0;
      active_p <= 1'b0;
    end else if (load_active) begin
      active_n <= eff_n;
      active_l <= eff_l;
      active_p <= eff_p;
    end
  end

endmodule
